// File: rtl/vga_disp_arbiter_if.sv
// vga_disp_arbiter_if
//   Write-side bundle between the two display-word requesters and the
//   display-register arbiter.
//   Port 0 (pipeline debug tap) and port 1 (serial/monitor console) each carry
//   req/addr/data towards the arbiter and get a one-cycle ack back.
//   Modports:
//     master - requester side: drives req/addr/data, observes ack
//     slave  - arbiter side:   observes req/addr/data, drives ack
interface vga_disp_arbiter_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          ack1;

    modport master (
        output req0, addr0, data0,
        input  ack0,
        output req1, addr1, data1,
        input  ack1
    );

    modport slave (
        input  req0, addr0, data0,
        output ack0,
        input  req1, addr1, data1,
        output ack1
    );
endinterface

// File: rtl/vga_disp_arbiter.sv
// vga_disp_arbiter
//   Double-buffered display register file shared by two write requesters.
//   Writes land in a shadow bank under round-robin arbitration; the shadow
//   bank is copied into the active bank on entry to vertical blank (only if
//   it was written since the last copy), so the painter never sees a torn
//   frame.
//   Ports:
//     clk        - system clock (scanner clock)
//     rst        - synchronous active-low reset
//     y          - current scan line from the scanner
//     wr         - write bundle (slave side): req/addr/data/ack for ports 0 and 1
//     rd_addr    - painter read address
//     rd_data    - active-bank word at rd_addr (combinational)
//     frame_swap - one-cycle pulse in the cycle after a commit
//     dirty      - shadow bank has been written since the last commit
//     frame_cnt  - number of commits, modulo 256
module vga_disp_arbiter #(
    parameter int unsigned WORDS    = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned DW       = 16,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          y,
    vga_disp_arbiter_if.slave    wr,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic                 frame_swap,
    output logic                 dirty,
    output logic [7:0]           frame_cnt
);

    localparam logic [10:0] V_ACTIVE_L = 11'(V_ACTIVE);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            blank_cmp_q;
    logic [DW-1:0]   shadow_q [WORDS];
    logic [DW-1:0]   active_q [WORDS];
    logic            ack0_q, ack1_q;
    logic            last_q;
    logic            dirty_q, dirty_d;
    logic            swap_q;
    logic [7:0]      cnt_q;

    logic            elig0, elig1;
    logic            gnt0, gnt1;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_in_range;
    logic            wr_en;
    logic            commit;

    // A port whose ack is showing is not eligible, so a requester that is
    // still dropping req cannot be served twice.
    always_comb begin
        elig0       = wr.req0 & ~ack0_q;
        elig1       = wr.req1 & ~ack1_q;
        // On a tie the port other than the last one served wins.
        gnt0        = elig0 & (~elig1 | last_q);
        gnt1        = elig1 & (~elig0 | ~last_q);
        wr_addr     = gnt1 ? wr.addr1 : wr.addr0;
        wr_data     = gnt1 ? wr.data1 : wr.data0;
        wr_in_range = 32'(wr_addr) < WORDS;
        wr_en       = (gnt0 | gnt1) & wr_in_range;
    end

    // Blank tracking: the commit fires on the ACTIVE->BLANK transition,
    // decided on the registered line compare.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (blank_cmp_q) begin
                    state_d = ST_BLANK;
                    commit  = dirty_q;
                end
            end
            ST_BLANK: begin
                if (!blank_cmp_q) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // A grant on the commit edge keeps dirty set: that write is only in the
    // shadow bank and still has to be committed at the next blank entry.
    always_comb begin
        dirty_d = dirty_q;
        if (wr_en) begin
            dirty_d = 1'b1;
        end else if (commit) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_ACTIVE;
            blank_cmp_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            last_q      <= 1'b1;
            dirty_q     <= 1'b0;
            swap_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            blank_cmp_q <= (y >= V_ACTIVE_L);
            ack0_q      <= gnt0;
            ack1_q      <= gnt1;
            if (gnt0 | gnt1) begin
                last_q <= gnt1;
            end
            dirty_q     <= dirty_d;
            swap_q      <= commit;
            if (commit) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_en) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    // The copy sees the shadow bank as it was before this edge, so a write
    // granted on the same edge is not part of this frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            active_q <= shadow_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < WORDS) begin
            rd_data = active_q[rd_addr];
        end
    end

    assign wr.ack0    = ack0_q;
    assign wr.ack1    = ack1_q;
    assign frame_swap = swap_q;
    assign dirty      = dirty_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: doc/vga_disp_arbiter.md
# vga_disp_arbiter

Display-register arbiter between the CPU debug datapath and the VGA scanner/painter pair. Two write requesters (port 0: pipeline debug tap for instruction/PC/register words; port 1: serial/monitor console) share one shadow bank of display words through a round-robin request/ack handshake. The painter reads a separate active bank. The shadow bank is committed to the active bank only on entry to vertical blank, so a visible frame never tears.

## Interface
- `WORDS`, 8: number of display words.
- `AW`, 3: address width, equal to log2(WORDS).
- `DW`, 16: display word width.
- `V_ACTIVE`, 480: first non-visible line number. Same value the scanner uses.

- `clk`  in  1  system clock, same clock as the scanner.
- `rst`  in  1  reset. Synchronous, active-low.
- `y`  in  11  current line number from the scanner.
- `req0`  in  1  port 0 write request. Held until `ack0`.
- `addr0`  in  AW  port 0 word address. Stable while `req0` is high.
- `data0`  in  DW  port 0 write data. Stable while `req0` is high.
- `ack0`  out  1  port 0 write-done pulse, one cycle.
- `req1`, `addr1`, `data1`, `ack1`: same as the port 0 signals, for port 1.
- `rd_addr`  in  AW  painter read address.
- `rd_data`  out  DW  active-bank word at `rd_addr`. Combinational read.
- `frame_swap`  out  1  one-cycle pulse, the cycle after a commit.
- `dirty`  out  1  shadow bank differs from the active bank (a write occurred since the last commit).
- `frame_cnt`  out  8  number of commits, modulo 256.

## Operation
- **Storage**: `shadow[WORDS]` and `active[WORDS]` registers, each DW bits wide.
  - Only the arbiter writes `shadow`.
  - Only the commit writes `active`, copying all words in one cycle.
- **Eligibility**: a port is eligible in a cycle when its `req` is high and its `ack` is low in that same cycle. This blocks a double write while the requester is dropping `req`.
- **Arbitration**: round-robin via a one-bit pointer `last`.
  - Only one port eligible: it is granted.
  - Both eligible: the port != `last` is granted.
  - On each grant, `last` takes the granted port number.
  - The grant, the `shadow[addr]<=data` write and the setting of `ack` all take effect on the same edge.
- **Blank-tracking FSM** (states ACTIVE, BLANK, decided on the registered compare `y >= V_ACTIVE`):
  - ACTIVE→BLANK when the compare is true. This is a commit edge.
  - BLANK→ACTIVE when the compare is false.
  - No other transitions.
- **Commit**, on the ACTIVE→BLANK edge, only if `dirty`=1:
  - `active` takes `shadow` as it was before that edge.
  - `frame_cnt` increments, wrapping 255→0.
  - `frame_swap` pulses in the following cycle.
  - If `dirty`=0 at the blank entry: no copy, no pulse, no count.
- **dirty rule**:
  - Set on any grant.
  - Cleared on a commit, unless a grant occurs on the same edge; the grant wins and `dirty` stays 1.
- **Same-edge write and commit**: the new write lands in `shadow` only and is committed at the next blank entry.
- **Same-address writes from both ports in back-to-back cycles**: the later grant's data persists.
- **Out of range**: `addr >= WORDS` when WORDS < 2^AW. The write is dropped, but `ack` is still pulsed and `dirty` is unchanged.
- **Reset** (`rst`=0 at an edge):
  - All `shadow`/`active` words 0.
  - `ack0`=`ack1`=0, `frame_swap`=0, `dirty`=0, `frame_cnt`=0.
  - `last`=1, so port 0 wins the first tie.
  - FSM in ACTIVE, registered compare 0.
  - Reset in mid-handshake abandons the request. The requester must keep `req` high, and it is re-served after reset is released.

## Timing
- Write latency: request sampled at edge N. `ack` is high during cycle N+1, and the data is visible in `shadow` after edge N.
- Minimum spacing between writes on one port: 2 cycles.
- Both ports continuously requesting: grants alternate, one write per cycle in aggregate.
- Commit: happens at the edge after the first cycle with `y >= V_ACTIVE` (one-cycle register delay). `frame_swap` is high in the next cycle. `rd_data` shows the new frame from that same edge.
- `rd_data` is combinational from `active` and `rd_addr`, with no added latency.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles with both `req` high. Then all outputs are 0 and `rd_data`=0 for every `rd_addr`. After release, port 0 is acked first.
- **Single write, held display**:
  - Port 0 writes 0xA5A5 to address 2 while `y`=100. `ack0` is high for exactly one cycle and `dirty`=1.
  - `rd_data`@2 stays 0 until `y` reaches 480. After the commit edge it reads 0xA5A5, `frame_swap` pulses once and `frame_cnt`=1.
- **Contention**: both ports hold `req` for 6 cycles, writing address 0 with 0x1111 (port 0) and 0x2222 (port 1). Acks alternate 0,1,0,1. After the next commit, address 0 holds the last granted port's data.
- **Clean blank**: with `dirty`=0, sweep `y` 479→480→524→0. There is no `frame_swap`, `frame_cnt` is unchanged and `active` is unchanged.
- **Write on commit edge**: time a port 1 write of 0x0F0F to address 5 onto the ACTIVE→BLANK edge.
  - `active`@5 stays at its old value and `dirty` stays 1.
  - At the following blank entry, `active`@5 becomes 0x0F0F.
- **Wrap and reset mid-handshake**:
  - 256 dirty frames bring `frame_cnt` to 0.
  - Assert `rst` while `req0` is high and `ack0` has not yet pulsed. No ack is given during reset, and the write completes within 2 cycles after release.
